// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared types and default sizes for the regfile write-port arbiter.
// Defaults match the machine's register file: 32 x 32-bit, 5-bit addresses.
package regfile_wr_arbiter_pkg;

  localparam int unsigned REG_NUM_DEF  = 32;
  localparam int unsigned ADDR_W_DEF   = 5;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned MAX_WAIT_DEF = 4;

  typedef enum logic {
    ARB_SCRUB = 1'b0,
    ARB_RUN   = 1'b1
  } arb_state_e;

endpackage

// File: rtl/regfile_wr_arbiter.sv
// Single write port of the register file, shared between pipeline writeback and one
// multi-cycle requester; zero-scrubs r1..r(REG_NUM-1) after reset.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int unsigned REG_NUM  = REG_NUM_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_waddr,
  input  logic [DATA_W-1:0] pipe_wdata,
  input  logic              mc_valid,
  output logic              mc_ready,
  input  logic [ADDR_W-1:0] mc_waddr,
  input  logic [DATA_W-1:0] mc_wdata,
  output logic              stall_req,
  output logic              busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              dbg_state
);

  localparam int unsigned       CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_NUM - 1);
  localparam logic [CNT_W-1:0]  WAIT_MAX = CNT_W'(MAX_WAIT);

  // Handshake: mc_valid && mc_ready in the same cycle; the requester holds
  // mc_waddr/mc_wdata stable until then, and mc_ready never depends on a future cycle.
  arb_state_e        r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [CNT_W-1:0]  r_wcnt;
  logic              r_starve;

  logic              w_pipe_hit;
  logic              w_mc_hit;
  logic              w_hs;
  logic [CNT_W-1:0]  w_wcnt_inc;

  assign w_pipe_hit = pipe_we && (pipe_waddr != '0);
  assign w_mc_hit   = mc_valid && (mc_waddr != '0);
  assign w_hs       = mc_valid && mc_ready;
  assign w_wcnt_inc = r_wcnt + CNT_W'(1);
  assign dbg_state  = r_state;

  // Outputs are combinational so a pipeline write reaches the regfile in the same cycle.
  always_comb begin
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    mc_ready  = 1'b0;
    stall_req = 1'b1;
    busy      = 1'b1;
    if (!rst) begin
      case (r_state)
        ARB_SCRUB: begin
          rf_we    = 1'b1;
          rf_waddr = r_idx;
        end
        ARB_RUN: begin
          busy      = 1'b0;
          stall_req = r_starve;
          if (w_pipe_hit) begin
            rf_we    = 1'b1;
            rf_waddr = pipe_waddr;
            rf_wdata = pipe_wdata;
          end else begin
            mc_ready = 1'b1;
            if (w_mc_hit) begin
              rf_we    = 1'b1;
              rf_waddr = mc_waddr;
              rf_wdata = mc_wdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ARB_SCRUB;
      r_idx    <= ADDR_W'(1);
      r_wcnt   <= '0;
      r_starve <= 1'b0;
    end else begin
      case (r_state)
        ARB_SCRUB: begin
          r_idx <= r_idx + ADDR_W'(1);
          if (r_idx == LAST_IDX) r_state <= ARB_RUN;
        end
        default: r_state <= ARB_RUN;
      endcase
      // starve rises on the edge the count reaches MAX_WAIT, so the stall lands one
      // cycle later and the handshake happens no later than MAX_WAIT+1.
      if (w_hs) begin
        r_wcnt   <= '0;
        r_starve <= 1'b0;
      end else if (!mc_valid) begin
        r_wcnt <= '0;
      end else if (r_wcnt != WAIT_MAX) begin
        r_wcnt <= w_wcnt_inc;
        if (w_wcnt_inc == WAIT_MAX) r_starve <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized and directed bench for regfile_wr_arbiter against a cycle-level
// behavioural model of the port-sharing rules.
module tb_regfile_wr_arbiter;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_waddr = '0;
  logic [31:0] pipe_wdata = '0;
  logic        mc_valid = 1'b0;
  logic        mc_ready;
  logic [4:0]  mc_waddr = '0;
  logic [31:0] mc_wdata = '0;
  logic        stall_req;
  logic        busy;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        dbg_state;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(
    .REG_NUM(32), .ADDR_W(5), .DATA_W(32), .MAX_WAIT(MAXW)
  ) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_waddr(mc_waddr), .mc_wdata(mc_wdata),
    .stall_req(stall_req), .busy(busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: next register to scrub (32 = scrub finished), unserved-wait count, starve flag.
  int          m_scrub = 1;
  int          m_wait  = 0;
  bit          m_starve = 1'b0;
  logic [40:0] exp_obs;
  logic        exp_ready;
  logic [36:0] exp_q[$];
  logic [36:0] obs_q[$];

  function automatic logic [40:0] pack_obs();
    return {rf_we, rf_we ? rf_waddr : 5'd0, rf_we ? rf_wdata : 32'd0, mc_ready, stall_req, busy};
  endfunction

  always @(negedge clk) if (rf_we === 1'b1) obs_q.push_back({rf_waddr, rf_wdata});

  task automatic eval();
    logic we, rdy, st, bz;
    logic [4:0] a;
    logic [31:0] d;
    @(negedge clk);
    we = 1'b0; a = '0; d = '0; rdy = 1'b0; st = 1'b1; bz = 1'b1;
    if (!rst) begin
      if (m_scrub < 32) begin
        we = 1'b1;
        a  = 5'(m_scrub);
      end else begin
        bz = 1'b0;
        st = m_starve;
        if (pipe_we && pipe_waddr != 0) begin
          we = 1'b1; a = pipe_waddr; d = pipe_wdata;
        end else begin
          rdy = 1'b1;
          if (mc_valid && mc_waddr != 0) begin
            we = 1'b1; a = mc_waddr; d = mc_wdata;
          end
        end
      end
    end
    exp_ready = rdy;
    exp_obs   = {we, a, d, rdy, st, bz};
    if (we) exp_q.push_back({a, d});
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_scrub = 1; m_wait = 0; m_starve = 1'b0;
    end else begin
      if (m_scrub < 32) m_scrub++;
      if (mc_valid && exp_ready) begin
        m_wait = 0; m_starve = 1'b0;
      end else if (!mc_valid) begin
        m_wait = 0;
      end else begin
        if (m_wait < MAXW) m_wait++;
        if (m_wait == MAXW) m_starve = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pipe_we = 1'b1; pipe_waddr = 5'($urandom_range(1, 31)); pipe_wdata = $urandom;
      mc_valid = 1'b1; mc_waddr = 5'($urandom_range(1, 31)); mc_wdata = $urandom;
      eval();
      n_checks++;
      if (pack_obs() !== exp_obs) $display("FAIL reset cyc=%0d got=%h exp=%h", i, pack_obs(), exp_obs);
      else n_pass++;
      advance();
    end
    mc_valid = 1'b0;
  endtask

  task automatic test_scrub();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      pipe_we = 1'($urandom_range(0, 1)); pipe_waddr = 5'($urandom); pipe_wdata = $urandom;
      eval();
      n_checks++;
      if (pack_obs() !== exp_obs) $display("FAIL scrub cyc=%0d got=%h exp=%h", i, pack_obs(), exp_obs);
      else n_pass++;
      if (i == 0 || i == 30 || i == 31) begin
        n_checks++;
        if (i < 31 && (rf_waddr !== 5'(i + 1) || busy !== 1'b1))
          $display("FAIL scrub_addr cyc=%0d got addr=%0d busy=%b exp addr=%0d busy=1", i, rf_waddr, busy, i + 1);
        else if (i == 31 && busy !== 1'b0)
          $display("FAIL scrub_done got busy=%b exp busy=0", busy);
        else n_pass++;
      end
      advance();
    end
    pipe_we = 1'b0;
  endtask

  task automatic test_contention();
    pipe_we = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'hAAAA0000;
    mc_valid = 1'b1; mc_waddr = 5'd6; mc_wdata = 32'h1234;
    eval();
    n_checks++;
    if (pack_obs() !== exp_obs) $display("FAIL contention_pipe got=%h exp=%h", pack_obs(), exp_obs);
    else n_pass++;
    advance();
    pipe_we = 1'b0;
    eval();
    n_checks++;
    if (pack_obs() !== exp_obs) $display("FAIL contention_mc got=%h exp=%h", pack_obs(), exp_obs);
    else n_pass++;
    n_checks++;
    if (!(rf_we === 1'b1 && rf_waddr === 5'd6 && rf_wdata === 32'h1234 && mc_ready === 1'b1))
      $display("FAIL contention_r6 got we=%b addr=%0d data=%h rdy=%b exp we=1 addr=6 data=00001234 rdy=1",
               rf_we, rf_waddr, rf_wdata, mc_ready);
    else n_pass++;
    advance();
    mc_valid = 1'b0;
  endtask

  task automatic test_starvation();
    bit hs = 1'b0;
    int hs_cyc = 0;
    mc_valid = 1'b1; mc_waddr = 5'd8; mc_wdata = $urandom;
    for (int c = 1; c <= 8 && !hs; c++) begin
      pipe_we = !stall_req; pipe_waddr = 5'd7; pipe_wdata = $urandom;
      eval();
      n_checks++;
      if (pack_obs() !== exp_obs) $display("FAIL starve cyc=%0d got=%h exp=%h", c, pack_obs(), exp_obs);
      else n_pass++;
      if (mc_valid && exp_ready) begin hs = 1'b1; hs_cyc = c; end
      advance();
    end
    n_checks++;
    if (!hs || hs_cyc != MAXW + 1) $display("FAIL starve_bound got hs=%b cyc=%0d exp hs=1 cyc=%0d", hs, hs_cyc, MAXW + 1);
    else n_pass++;
    mc_valid = 1'b0; pipe_we = 1'b1;
    eval();
    n_checks++;
    if (pack_obs() !== exp_obs || stall_req !== 1'b0)
      $display("FAIL starve_release got=%h stall=%b exp=%h stall=0", pack_obs(), stall_req, exp_obs);
    else n_pass++;
    advance();
    pipe_we = 1'b0;
  endtask

  task automatic test_r0();
    pipe_we = 1'b1; pipe_waddr = 5'd0; pipe_wdata = $urandom;
    mc_valid = 1'b1; mc_waddr = 5'd9; mc_wdata = $urandom;
    eval();
    n_checks++;
    if (pack_obs() !== exp_obs) $display("FAIL r0_pipe got=%h exp=%h", pack_obs(), exp_obs);
    else n_pass++;
    advance();
    pipe_we = 1'b0; mc_waddr = 5'd0; mc_wdata = $urandom;
    eval();
    n_checks++;
    if (pack_obs() !== exp_obs || rf_we !== 1'b0 || mc_ready !== 1'b1)
      $display("FAIL r0_mc got=%h exp=%h", pack_obs(), exp_obs);
    else n_pass++;
    advance();
    mc_valid = 1'b0;
  endtask

  task automatic test_random();
    bit hs;
    for (int i = 0; i < 400; i++) begin
      if (!mc_valid && $urandom_range(0, 2) == 0) begin
        mc_valid = 1'b1; mc_waddr = 5'($urandom); mc_wdata = $urandom;
      end
      pipe_we = ($urandom_range(0, 3) != 0) && (!stall_req || $urandom_range(0, 7) == 0);
      pipe_waddr = 5'($urandom); pipe_wdata = $urandom;
      eval();
      n_checks++;
      if (pack_obs() !== exp_obs) $display("FAIL random cyc=%0d got=%h exp=%h", i, pack_obs(), exp_obs);
      else n_pass++;
      hs = mc_valid && exp_ready;
      advance();
      if (hs) mc_valid = 1'b0;
    end
    pipe_we = 1'b0; mc_valid = 1'b0;
  endtask

  task automatic test_reset_mid_scrub();
    rst = 1'b1;
    eval(); advance();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin eval(); advance(); end
    rst = 1'b1; mc_valid = 1'b1; mc_waddr = 5'd14; mc_wdata = $urandom;
    for (int i = 0; i < 2; i++) begin
      eval();
      n_checks++;
      if (pack_obs() !== exp_obs) $display("FAIL midscrub_rst cyc=%0d got=%h exp=%h", i, pack_obs(), exp_obs);
      else n_pass++;
      advance();
    end
    rst = 1'b0; mc_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      eval();
      n_checks++;
      if (pack_obs() !== exp_obs || (i == 0 && rf_waddr !== 5'd1))
        $display("FAIL midscrub_rescrub cyc=%0d got=%h exp=%h", i, pack_obs(), exp_obs);
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_reset_mid_run();
    mc_valid = 1'b1; mc_waddr = 5'd12; mc_wdata = $urandom;
    pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = $urandom;
    for (int i = 0; i < 2; i++) begin eval(); advance(); end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      eval();
      n_checks++;
      if (pack_obs() !== exp_obs || mc_ready !== 1'b0)
        $display("FAIL midrun_rst cyc=%0d got=%h exp=%h", i, pack_obs(), exp_obs);
      else n_pass++;
      advance();
    end
    rst = 1'b0; mc_valid = 1'b0; pipe_we = 1'b0;
    for (int i = 0; i < 33; i++) begin
      eval();
      n_checks++;
      if (pack_obs() !== exp_obs) $display("FAIL midrun_rescrub cyc=%0d got=%h exp=%h", i, pack_obs(), exp_obs);
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_write_log();
    int bad = -1;
    int n = (exp_q.size() < obs_q.size()) ? exp_q.size() : obs_q.size();
    for (int i = 0; i < n && bad < 0; i++) if (exp_q[i] !== obs_q[i]) bad = i;
    n_checks++;
    if (exp_q.size() != obs_q.size() || bad >= 0)
      $display("FAIL write_log got size=%0d exp size=%0d first_diff=%0d", obs_q.size(), exp_q.size(), bad);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_scrub();
    test_contention();
    test_starvation();
    test_r0();
    test_random();
    test_reset_mid_scrub();
    test_reset_mid_run();
    test_write_log();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Owns the single write port of `regfile` and shares it between the in-order pipeline writeback and one multi-cycle requester such as the divider or a load-miss return. After reset it first scrubs r1..r31 to zero, because the register array itself is never reset. In normal operation the pipeline has priority; a starvation counter forces a pipeline stall so the multi-cycle unit always completes. The block sits between MEM/WB, the multi-cycle unit and `regfile`, and feeds the `ctrl` stall logic.

## Interface
- `REG_NUM`, 32: number of architectural registers; r0 is hard-wired zero and is never written.
- `ADDR_W`, 5: register address width (log2 `REG_NUM`).
- `DATA_W`, 32: register data width.
- `MAX_WAIT`, 4: number of cycles `mc_valid` may go unserved before a stall is forced; must be ≥1.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `pipe_we`  in  1  pipeline writeback enable
- `pipe_waddr`  in  ADDR_W  pipeline destination register
- `pipe_wdata`  in  DATA_W  pipeline write data
- `mc_valid`  in  1  multi-cycle result pending
- `mc_ready`  out  1  multi-cycle result accepted this cycle
- `mc_waddr`  in  ADDR_W  multi-cycle destination register
- `mc_wdata`  in  DATA_W  multi-cycle result
- `stall_req`  out  1  to `ctrl`: pipeline must hold `pipe_we`=0
- `busy`  out  1  scrub in progress
- `rf_we`  out  1  to `regfile` `we`
- `rf_waddr`  out  ADDR_W  to `regfile` `waddr`
- `rf_wdata`  out  DATA_W  to `regfile` `wdata`

## Operation
- FSM states: SCRUB and RUN. While `rst`=1 the next state is SCRUB and `idx` is set to 1.
- **SCRUB**
  - Each cycle drives `rf_we`=1, `rf_waddr`=`idx`, `rf_wdata`=0, then increments `idx`.
  - When `idx`=REG_NUM-1 the FSM moves to RUN on the next edge.
  - Outputs: `busy`=1, `stall_req`=1, `mc_ready`=0. `pipe_we` is ignored.
- **RUN, port select, checked in priority order**
  1. `pipe_we`=1 and `pipe_waddr`≠0: the pipeline write is forwarded and `mc_ready`=0. This holds even while `stall_req`=1 (a protocol violation; pipeline data integrity wins).
  2. Otherwise `mc_ready`=1.
     - If `mc_valid`=1 and `mc_waddr`≠0: the multi-cycle write is forwarded.
     - If `mc_valid`=1 and `mc_waddr`=0: the handshake completes and `rf_we`=0 (the write is dropped).
  3. Otherwise `rf_we`=0.
- A pipeline write to r0 counts as idle, so the multi-cycle unit may take the port in that cycle.
- **Starvation**
  - `wcnt` (width clog2(MAX_WAIT+1)) increments each cycle `mc_valid`=1 and `mc_ready`=0, saturating at MAX_WAIT.
  - `wcnt` clears on a handshake or when `mc_valid`=0.
  - Registered `starve` is set when `wcnt` reaches MAX_WAIT and cleared on handshake.
  - In RUN, `stall_req`=`starve`.
- Handshake means `mc_valid`=1 and `mc_ready`=1 in the same cycle. The multi-cycle unit holds `mc_waddr`/`mc_wdata` stable until then.
- Same-address writes in one cycle: the pipeline wins and the multi-cycle write lands in a later cycle. WAW ordering is the issue logic's responsibility.

## Timing
- `rf_*`, `mc_ready`, `stall_req` and `busy` are combinational from registered state and current inputs. There are zero cycles from `pipe_we` to `rf_we`, so the regfile write-bypass forwarding still works.
- While `rst`=1: `rf_we`=0, `mc_ready`=0, `busy`=1, `stall_req`=1.
- Scrub covers r1..r31: exactly REG_NUM-1 = 31 cycles after `rst` falls. RUN starts on cycle 32.
- Reset asserted mid-scrub restarts the scrub at r1. Reset asserted mid-RUN clears `wcnt`/`starve`, drops any pending multi-cycle result and rescrubs.
- Starvation bound: with continuous pipeline writes, a handshake occurs no later than cycle MAX_WAIT+1 after `mc_valid` rises, given `ctrl` honours `stall_req` in the same cycle.

## Structure
- `REG_NUM`/`ADDR_W`/`DATA_W` defaults map to the existing `RegNum`, `RegAddrBus`, `RegBus`, `WriteEnable` and `ZeroWord` macros in `defines.v`.
- The FSM state encodings (`ArbScrub`, `ArbRun`) are added to `defines.v`.
- Single flat module, no sub-modules: the scrub index and wait counter are simple enough to keep inline.

## Test plan
- **Scrub:** release `rst` → `rf_we`=1 for 31 cycles with `rf_waddr`=1..31 and `rf_wdata`=0, `busy`/`stall_req`=1; cycle 32 shows `busy`=0.
- **Contention:** `pipe_we`=1 to r5 with 0xAAAA0000 and `mc_valid` to r6 with 0x1234 → r5 written first, `mc_ready`=0. Next cycle with `pipe_we`=0 → handshake and r6=0x1234.
- **Starvation (MAX_WAIT=4):** `pipe_we`=1 to r7 every cycle and `mc_valid` held → `stall_req` rises after 4 waiting cycles. When the bench drops `pipe_we`, `mc_ready`=1, then `stall_req` falls.
- **r0 handling:** pipeline write to r0 plus `mc_valid` to r9 → r9 written that cycle. A multi-cycle request to r0 → `mc_ready`=1 with `rf_we`=0.
- **Reset mid-scrub (cycle 10) and mid-RUN with `mc_valid` pending** → scrub restarts at r1, `mc_ready`=0 throughout, and no stale write appears.
